// File: rtl/tcm_enc_4d8psk_r2_if.sv
// Stream bundle for the 4D-8PSK rate-8/9 TCM encoder: symbol input
// handshake plus the encoded output stream.
interface tcm_enc_4d8psk_r2_if #(
   parameter int pCNT_W = 16
);
   logic              ival;
   logic              isop;
   logic              ieop;
   logic [7:0]        idat;
   logic              oval;
   logic              osop;
   logic              oeop;
   logic              oerr;
   logic [11:0]       osym;
   logic [pCNT_W-1:0] ocnt;

   modport master (
      output ival, isop, ieop, idat,
      input  oval, osop, oeop, oerr, osym, ocnt
   );

   modport slave (
      input  ival, isop, ieop, idat,
      output oval, osop, oeop, oerr, osym, ocnt
   );
endinterface

// File: rtl/tcm_enc_4d8psk_r2.sv
// 4D-8PSK trellis-coded modulation encoder, 64-state systematic feedback
// code. Each enabled clock accepts one 4D symbol (8 info bits), adds the
// parity bit x0 from the encoder state and maps to four 8PSK phases.
// Two register stages: coded bits, then phase mapping / frame counter.
module tcm_enc_4d8psk_r2 #(
   parameter int         pCNT_W = 16,
   parameter logic [5:0] pC0    = 6'h21,
   parameter logic [5:0] pC1    = 6'h0E,
   parameter logic [5:0] pC2    = 6'h16,
   parameter logic [5:0] pC3    = 6'h0A
) (
   input  logic               iclk,
   input  logic               ireset,
   input  logic               iclkena,
   tcm_enc_4d8psk_r2_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

   // Phase addition wraps naturally in 3 bits (mod 8).
   function automatic logic [2:0] add_mod8(input logic [2:0] a, input logic [2:0] b);
      return a + b;
   endfunction

   // Frame symbol counter sticks at all-ones rather than wrapping.
   function automatic logic [pCNT_W-1:0] sat_inc(input logic [pCNT_W-1:0] v);
      if (&v) return v;
      return v + {{(pCNT_W-1){1'b0}}, 1'b1};
   endfunction

   state_t            fsm_q, fsm_d;
   logic [5:0]        s_q, s_d, s_use;
   logic              x0;
   logic              err_d;

   logic              vld_p1_q;
   logic [3:0]        x_p1_q;
   logic [4:0]        u_p1_q;
   logic              sop_p1_q, eop_p1_q, err_p1_q;

   logic              oval_q, osop_q, oeop_q, oerr_q;
   logic [11:0]       osym_q, osym_d;
   logic [pCNT_W-1:0] ocnt_q, ocnt_d;

   logic [2:0]        y0, y1, y2, y3;

   // Encoder next state and framing decisions for the symbol at the input.
   always_comb begin
      s_use = (bus.ival && bus.isop) ? 6'd0 : s_q;
      x0    = s_use[0];
      s_d   = {1'b0, s_use[5:1]};
      if (x0)          s_d = s_d ^ pC0;
      if (bus.idat[0]) s_d = s_d ^ pC1;
      if (bus.idat[1]) s_d = s_d ^ pC2;
      if (bus.idat[2]) s_d = s_d ^ pC3;
      fsm_d = fsm_q;
      err_d = 1'b0;
      if (bus.isop) begin
         err_d = (fsm_q == FRAME);
         fsm_d = bus.ieop ? IDLE : FRAME;
      end else begin
         err_d = (fsm_q == IDLE);
         if (bus.ieop) fsm_d = IDLE;
      end
   end

   // Encoder state and frame FSM advance only on accepted symbols.
   always_ff @(posedge iclk) begin
      if (!ireset) begin
         s_q   <= 6'd0;
         fsm_q <= IDLE;
      end else if (iclkena && bus.ival) begin
         s_q   <= s_d;
         fsm_q <= fsm_d;
      end
   end

   // Stage 1: coded bits x0..x3, uncoded bits u0..u4 and frame flags.
   always_ff @(posedge iclk) begin
      if (!ireset) begin
         vld_p1_q <= 1'b0;
         x_p1_q   <= 4'd0;
         u_p1_q   <= 5'd0;
         sop_p1_q <= 1'b0;
         eop_p1_q <= 1'b0;
         err_p1_q <= 1'b0;
      end else if (iclkena) begin
         vld_p1_q <= bus.ival;
         x_p1_q   <= {bus.idat[2:0], x0};
         u_p1_q   <= bus.idat[7:3];
         sop_p1_q <= bus.isop;
         eop_p1_q <= bus.ieop;
         err_p1_q <= err_d;
      end
   end

   // 8PSK mapping: y0 carries x0/x1/u0, the other phases are offsets from y0.
   always_comb begin
      y0     = {u_p1_q[0], x_p1_q[1], x_p1_q[0]};
      y1     = add_mod8(y0, {u_p1_q[1], x_p1_q[2], 1'b0});
      y2     = add_mod8(y0, {u_p1_q[2], x_p1_q[3], 1'b0});
      y3     = add_mod8(y0, {u_p1_q[3], u_p1_q[4], 1'b0});
      osym_d = {y3, y2, y1, y0};
      ocnt_d = sop_p1_q ? '0 : sat_inc(ocnt_q);
   end

   // Stage 2: output register; flags are gated by valid so none stray alone.
   always_ff @(posedge iclk) begin
      if (!ireset) begin
         oval_q <= 1'b0;
         osop_q <= 1'b0;
         oeop_q <= 1'b0;
         oerr_q <= 1'b0;
         osym_q <= 12'd0;
         ocnt_q <= '0;
      end else if (iclkena) begin
         oval_q <= vld_p1_q;
         osop_q <= vld_p1_q & sop_p1_q;
         oeop_q <= vld_p1_q & eop_p1_q;
         oerr_q <= vld_p1_q & err_p1_q;
         if (vld_p1_q) begin
            osym_q <= osym_d;
            ocnt_q <= ocnt_d;
         end
      end
   end

   assign bus.oval = oval_q;
   assign bus.osop = osop_q;
   assign bus.oeop = oeop_q;
   assign bus.oerr = oerr_q;
   assign bus.osym = osym_q;
   assign bus.ocnt = ocnt_q;

endmodule

// File: tb/tb_tcm_enc_4d8psk_r2.sv
// Bench for tcm_enc_4d8psk_r2: table vectors for the worked examples,
// a reference encoder model feeding a scoreboard for the remaining cases.
module tb_tcm_enc_4d8psk_r2;

   localparam int         CNT_W = 3;
   localparam logic [5:0] C0 = 6'h21, C1 = 6'h0E, C2 = 6'h16, C3 = 6'h0A;

   logic iclk = 1'b0;
   logic ireset;
   logic iclkena;

   tcm_enc_4d8psk_r2_if #(.pCNT_W(CNT_W)) bus ();

   tcm_enc_4d8psk_r2 #(.pCNT_W(CNT_W)) dut (
      .iclk    (iclk),
      .ireset  (ireset),
      .iclkena (iclkena),
      .bus     (bus)
   );

   always #5 iclk = ~iclk;

   typedef struct {
      logic [11:0]      sym;
      logic [CNT_W-1:0] cnt;
      bit               sop, eop, err;
      int               tag;
   } exp_t;

   typedef struct {
      logic [7:0]  dat;
      bit          sop, eop;
      logic [11:0] sym;
      int          cnt;
      bit          err;
   } vec_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   en_cyc  = 0;
   logic last_en = 1'b0;

   logic [5:0]       m_s;
   bit               m_frame;
   logic [CNT_W-1:0] m_cnt;

   always @(posedge iclk) begin
      last_en <= iclkena;
      if (iclkena) en_cyc <= en_cyc + 1;
   end

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input logic [11:0] sym, input int cnt, input bit sop, eop, err);
      exp_t e;
      e.sym = sym; e.cnt = cnt[CNT_W-1:0]; e.sop = sop; e.eop = eop; e.err = err;
      e.tag = en_cyc;
      q.push_back(e);
   endtask

   // Reference encoder: computes the expected output of one symbol and advances.
   task automatic push_model(input logic [7:0] d, input bit sop, eop);
      logic [5:0] su, ns;
      int x0, x1, x2, x3, y0, y1, y2, y3;
      bit err;
      logic [11:0] sym;
      su  = sop ? 6'd0 : m_s;
      err = sop ? m_frame : !m_frame;
      x0 = su[0]; x1 = d[0]; x2 = d[1]; x3 = d[2];
      y0 = (4*d[3] + 2*x1 + x0) % 8;
      y1 = (y0 + 4*d[4] + 2*x2) % 8;
      y2 = (y0 + 4*d[5] + 2*x3) % 8;
      y3 = (y0 + 4*d[6] + 2*d[7]) % 8;
      sym = {y3[2:0], y2[2:0], y1[2:0], y0[2:0]};
      ns = su >> 1;
      if (x0 != 0) ns = ns ^ C0;
      if (x1 != 0) ns = ns ^ C1;
      if (x2 != 0) ns = ns ^ C2;
      if (x3 != 0) ns = ns ^ C3;
      m_s = ns;
      if (sop) m_frame = !eop;
      else if (eop) m_frame = 1'b0;
      if (sop) m_cnt = '0;
      else if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      push_exp(sym, int'(m_cnt), sop, eop, err);
   endtask

   task automatic drive(input logic [7:0] d, input bit sop, eop);
      bus.ival = 1'b1; bus.isop = sop; bus.ieop = eop; bus.idat = d;
      iclkena = 1'b1;
      @(posedge iclk); #1;
   endtask

   task automatic idle(input int n);
      bus.ival = 1'b0; bus.isop = 1'b0; bus.ieop = 1'b0; bus.idat = 8'h00;
      iclkena = 1'b1;
      repeat (n) begin @(posedge iclk); #1; end
   endtask

   task automatic model_send(input logic [7:0] d, input bit sop, eop);
      push_model(d, sop, eop);
      drive(d, sop, eop);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_oval"}, bus.oval, 0);
      chk({tag, "_osop"}, bus.osop, 0);
      chk({tag, "_oeop"}, bus.oeop, 0);
      chk({tag, "_oerr"}, bus.oerr, 0);
      chk({tag, "_osym"}, bus.osym, 0);
      chk({tag, "_ocnt"}, bus.ocnt, 0);
   endtask

   vec_t tbl[7];

   initial begin
      tbl[0] = '{8'h00, 1, 0, 12'h000, 0, 0};
      tbl[1] = '{8'h00, 0, 0, 12'h000, 1, 0};
      tbl[2] = '{8'h00, 0, 0, 12'h000, 2, 0};
      tbl[3] = '{8'h00, 0, 1, 12'h000, 3, 0};
      tbl[4] = '{8'h01, 1, 0, 12'h492, 0, 0};
      tbl[5] = '{8'h00, 0, 0, 12'h000, 1, 0};
      tbl[6] = '{8'h00, 0, 1, 12'h249, 2, 0};

      m_s = 6'd0; m_frame = 1'b0; m_cnt = '0;
      ireset = 1'b0; iclkena = 1'b1;
      bus.ival = 1'b0; bus.isop = 1'b0; bus.ieop = 1'b0; bus.idat = 8'h00;

      // Output monitor: pops the scoreboard on every enabled-edge output.
      fork
         forever begin
            exp_t e;
            @(negedge iclk);
            if (bus.oerr && !bus.oval) chk("oerr_without_oval", 1, 0);
            if (last_en && bus.oval) begin
               if (q.size() == 0) chk("unexpected_oval", 1, 0);
               else begin
                  e = q.pop_front();
                  chk("osym", bus.osym, e.sym);
                  chk("ocnt", bus.ocnt, e.cnt);
                  chk("osop", bus.osop, e.sop);
                  chk("oeop", bus.oeop, e.eop);
                  chk("oerr", bus.oerr, e.err);
                  chk("latency", en_cyc - e.tag, 2);
               end
            end
         end
      join_none

      repeat (3) @(posedge iclk);
      #1 ireset = 1'b1;
      @(negedge iclk);
      chk_zero_outputs("reset");
      #1;

      // Worked examples: all-zero frame, then the x1 impulse frame.
      for (int i = 0; i < 7; i++) begin
         push_exp(tbl[i].sym, tbl[i].cnt, tbl[i].sop, tbl[i].eop, tbl[i].err);
         drive(tbl[i].dat, tbl[i].sop, tbl[i].eop);
      end
      m_s = 6'h22; m_frame = 1'b0; m_cnt = 3'd2;

      // Symbol without sop while idle: flagged, encoded from current state.
      model_send(8'hA5, 0, 0);
      // One-symbol frame.
      model_send(8'h5A, 1, 1);
      // Second sop inside a frame restarts the encoder and counter.
      model_send(8'h37, 1, 0);
      model_send(8'hC3, 0, 0);
      model_send(8'h0F, 0, 0);
      model_send(8'hF1, 1, 0);
      model_send(8'h6E, 0, 0);
      model_send(8'h92, 0, 1);
      idle(1);

      // Long frame drives ocnt into saturation.
      for (int i = 0; i < 10; i++) model_send(8'($urandom), i == 0, i == 9);
      idle(3);

      // Continuous ival with the clock enable toggling every cycle.
      for (int i = 0; i < 8; i++) begin
         model_send(8'($urandom), i == 0, i == 7);
         iclkena = 1'b0;
         @(posedge iclk); #1;
      end
      idle(4);
      chk("drain_toggle", q.size(), 0);

      // Reset between ival and oval, with enable low: symbol is discarded.
      drive(8'h3C, 1, 0);
      bus.ival = 1'b0; bus.isop = 1'b0; bus.ieop = 1'b0;
      ireset = 1'b0; iclkena = 1'b0;
      @(posedge iclk); #1;
      ireset = 1'b1; iclkena = 1'b1;
      @(negedge iclk);
      chk_zero_outputs("midreset");
      for (int i = 0; i < 3; i++) begin
         @(negedge iclk);
         chk("midreset_no_oval", bus.oval, 0);
      end
      @(posedge iclk); #1;
      m_s = 6'd0; m_frame = 1'b0; m_cnt = '0;
      model_send(8'h01, 1, 0);
      model_send(8'h00, 0, 0);
      model_send(8'h00, 0, 1);

      // Random back-to-back frames of assorted lengths.
      for (int f = 0; f < 6; f++) begin
         int len;
         len = $urandom_range(1, 5);
         for (int i = 0; i < len; i++) model_send(8'($urandom), i == 0, i == len - 1);
      end
      idle(5);
      chk("queue_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tcm_enc_4d8psk_r2.md
TCM_ENC_4D8PSK_R2 -- requirements
Module: tcm_enc_4d8psk_r2

Interface
REQ-001 Parameter pCNT_W, default 16, width of per-frame 4D-symbol counter.
REQ-002 Parameter pC0, default 6'h21, state feedback mask for parity bit x0.
REQ-003 Parameter pC1, default 6'h0E, state mask for coded bit x1.
REQ-004 Parameter pC2, default 6'h16, state mask for coded bit x2.
REQ-005 Parameter pC3, default 6'h0A, state mask for coded bit x3.
REQ-006 Port iclk  in  1  single clock, all logic on rising edge.
REQ-007 Port ireset  in  1  reset, synchronous and active-low; one clock, no asynchronous reset anywhere.
REQ-008 Port iclkena  in  1  clock enable; when low, no register changes (reset excepted).
REQ-009 Port ival  in  1  input 4D-symbol valid.
REQ-010 Port isop  in  1  first 4D symbol of frame, qualified by ival.
REQ-011 Port ieop  in  1  last 4D symbol of frame, qualified by ival.
REQ-012 Port idat  in  8  info bits: x1=idat[0], x2=idat[1], x3=idat[2], u0..u4=idat[3..7].
REQ-013 Port oval  out  1  output valid.
REQ-014 Port osop  out  1  delayed isop.
REQ-015 Port oeop  out  1  delayed ieop.
REQ-016 Port osym  out  4x3  8PSK phase indices y0..y3 (y0 in [2:0]).
REQ-017 Port ocnt  out  pCNT_W  index of current output 4D symbol within frame.
REQ-018 Port oerr  out  1  one-cycle pulse on framing error.

Function
REQ-019 Encoder state s[5:0]; parity x0 = s[0] of the state used for the current symbol.
REQ-020 Next state s' = {0,s[5:1]} XOR (x0?pC0:0) XOR (x1?pC1:0) XOR (x2?pC2:0) XOR (x3?pC3:0); updated only on ival and iclkena.
REQ-021 On ival&isop the symbol is encoded from s=0 (state cleared before use), regardless of previous state.
REQ-022 Mapping, all mod 8: y0=4u0+2x1+x0; y1=y0+4u1+2x2; y2=y0+4u2+2x3; y3=y0+4u3+2u4.
REQ-023 Pipeline: stage 1 registers x0..x3,u0..u4,sop,eop; stage 2 registers osym, osop, oeop, ocnt; oval asserts exactly 2 enabled cycles after ival.
REQ-024 Back-to-back ival every cycle sustained; throughput one 4D symbol per enabled clock.
REQ-025 iclkena low freezes state, pipeline and valid shift register; outputs hold.
REQ-026 Frame FSM states IDLE, FRAME: IDLE->FRAME on ival&isop&!ieop; FRAME->IDLE on ival&ieop; ival&isop&ieop is a one-symbol frame, stays IDLE.
REQ-027 ival&isop in FRAME: oerr pulse aligned with that symbol's oval, new frame starts (state cleared, ocnt restarts).
REQ-028 ival&!isop in IDLE: symbol encoded with current state, oerr pulse aligned with its oval, FSM stays IDLE.
REQ-029 ocnt=0 on osop symbol, +1 per subsequent oval, saturates at all-ones.
REQ-030 osop, oeop, oerr, osym, ocnt are meaningful only when oval=1; oerr never asserts without oval.

Reset
REQ-031 ireset low at a rising edge: s=0, FSM=IDLE, valid pipeline cleared, oval=0, osop=0, oeop=0, oerr=0, osym=0, ocnt=0.
REQ-032 Reset has priority over iclkena; reset mid-frame discards in-flight symbols, no oval for them.

Verification
REQ-033 isop, idat=8'h00, then 3 symbols idat=8'h00 -> osym all 0 for each, ocnt 0..3, s stays 0.
REQ-034 isop idat=8'h01, then 8'h00, 8'h00 (ieop on last) -> osym {2,2,2,2}, {0,0,0,0}, {1,1,1,1}; states 0E, 07, 22; oeop on third.
REQ-035 Continuous ival with iclkena toggling 1010... -> oval count equals ival count, latency 2 enabled cycles, data unchanged.
REQ-036 Second isop mid-frame -> oerr=1 with that symbol, ocnt=0, encoding restarts from s=0.
REQ-037 ireset low for one cycle between ival and oval -> no oval appears, all outputs 0, next isop frame encodes correctly.
